// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction loader.
// Holds the loader state encoding, address width and default memory depth.
package instr_pkg;

  localparam int ADDR_W        = 8;
  localparam int ADDR_SPACE    = 1 << ADDR_W;
  localparam int MEM_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // True when an image of n bytes is not a whole number of words.
  function automatic logic len_misaligned(input logic [8:0] n);
    return n[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-wide instruction store: one synchronous write port and a
// combinational 4-byte big-endian read port with 8-bit address wrap.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr -> o_rdata (read).
module instr_byte_ram
  import instr_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  // Sized to the full address space so wrapped reads always land in range.
  // No reset: contents persist across loads and resets.
  logic [7:0] r_mem [ADDR_SPACE];

  logic [ADDR_W-1:0] w_a1;
  logic [ADDR_W-1:0] w_a2;
  logic [ADDR_W-1:0] w_a3;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_a1 = i_raddr + 8'd1;
  assign w_a2 = i_raddr + 8'd2;
  assign w_a3 = i_raddr + 8'd3;

  assign o_rdata = {r_mem[i_raddr], r_mem[w_a1],
                    r_mem[w_a2],    r_mem[w_a3]};

endmodule

// File: rtl/instr_loader.sv
// Loads a big-endian byte stream into instruction memory, then serves
// 32-bit fetches. Ports: clk/rst_n, start, in_* stream, fetch_addr/instr,
// status busy/done/err_overflow/err_align and byte_count.
module instr_loader
  import instr_pkg::*;
#(
  parameter int          MEM_DEPTH = MEM_DEPTH_DEF,
  parameter logic [7:0]  BASE_ADDR = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [7:0]  fetch_addr,
  output logic [31:0] fetch_instr,
  output logic        busy,
  output logic        done,
  output logic        err_overflow,
  output logic        err_align,
  output logic [8:0]  byte_count
);

  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

  state_e      r_state;
  logic [7:0]  r_wr_ptr;
  logic [8:0]  r_count;
  logic        r_err_ovf;
  logic        r_err_align;

  logic        w_in_ready;
  logic        w_accept;
  logic [8:0]  w_count_nx;
  logic [31:0] w_rdata;

  assign w_in_ready = (r_state == ST_LOAD) && (r_count < DEPTH);
  assign w_accept   = in_valid && w_in_ready;
  assign w_count_nx = r_count + 9'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= BASE_ADDR;
      r_count     <= '0;
      r_err_ovf   <= 1'b0;
      r_err_align <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          // A full image with no in_last retires to ERROR one
          // cycle after the final byte lands.
          if (r_count >= DEPTH) begin
            r_state   <= ST_ERROR;
            r_err_ovf <= 1'b1;
          end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 8'd1;
            r_count  <= w_count_nx;
            if (in_last) begin
              r_state     <= ST_DONE;
              r_err_align <= len_misaligned(w_count_nx);
            end
          end
        end
        default: begin
          if (start) begin
            r_state     <= ST_LOAD;
            r_wr_ptr    <= BASE_ADDR;
            r_count     <= '0;
            r_err_ovf   <= 1'b0;
            r_err_align <= 1'b0;
          end
        end
      endcase
    end
  end

  instr_byte_ram u_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (fetch_addr),
    .o_rdata (w_rdata)
  );

  assign in_ready     = w_in_ready;
  assign busy         = (r_state == ST_LOAD);
  assign done         = (r_state == ST_DONE);
  assign err_overflow = r_err_ovf;
  assign err_align    = r_err_align;
  assign byte_count   = r_count;
  assign fetch_instr  = done ? w_rdata : 32'h0;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed sequence with random image bytes,
// checked against a byte-array reference model of the loader.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  fetch_addr;
  logic [31:0] fetch_instr;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic        err_align;
  logic [8:0]  byte_count;

  always #5 clk = ~clk;

  instr_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .fetch_addr   (fetch_addr),
    .fetch_instr  (fetch_instr),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .err_align    (err_align),
    .byte_count   (byte_count)
  );

  // Reference model: memory image plus loader status.
  logic [7:0] mdl [256];
  int  m_ptr;
  int  m_cnt;
  bit  m_load;
  bit  m_done;
  bit  m_ovf;
  bit  m_align;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_fetch(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    if (!m_done) return 32'h0;
    return {mdl[a], mdl[b1], mdl[b2], mdl[b3]};
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_busy"},  32'(busy),         32'(m_load));
    chk({tag, "_done"},  32'(done),         32'(m_done));
    chk({tag, "_count"}, 32'(byte_count),   32'(m_cnt));
    chk({tag, "_ovf"},   32'(err_overflow), 32'(m_ovf));
    chk({tag, "_align"}, 32'(err_align),    32'(m_align));
    chk({tag, "_ready"}, 32'(in_ready),
        32'(m_load && m_cnt < 256));
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] a);
    fetch_addr = a;
    #1;
    chk(tag, fetch_instr, exp_fetch(a));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_load = 0;
    m_done = 0;
    m_cnt  = 0;
    m_ptr  = 0;
    m_ovf  = 0;
    m_align = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    m_load = 1;
    m_done = 0;
    m_cnt  = 0;
    m_ptr  = 0;
    m_ovf  = 0;
    m_align = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last,
                           input int gap);
    int w;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 8) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mdl[m_ptr] = d;
    m_ptr = (m_ptr + 1) % 256;
    m_cnt++;
    if (last) begin
      m_load  = 0;
      m_done  = 1;
      m_align = (m_cnt % 4) != 0;
    end
  endtask

  task automatic load_image(input int n, input bit last, input int gmax);
    do_start();
    for (int i = 0; i < n; i++)
      send_byte(8'($urandom), last && (i == n - 1),
                $urandom_range(gmax, 0));
  endtask

  logic [7:0] img [8];

  initial begin
    img = '{8'h00, 8'h22, 8'h18, 8'h20, 8'h04, 8'h43, 8'h28, 8'h22};
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    fetch_addr = 8'h00;
    m_ptr = 0;
    m_cnt = 0;

    // Reset state.
    do_reset();
    check_status("reset");
    check_fetch("reset_fetch", 8'h10);

    // Overflow: 256 bytes with no in_last, then a 257th offered.
    load_image(256, 0, 0);
    chk("ovf_ready_after256", 32'(in_ready), 32'd0);
    chk("ovf_count_after256", 32'(byte_count), 32'd256);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(posedge clk);
    #1;
    m_load = 0;
    m_ovf  = 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_status("ovf");
    check_fetch("ovf_fetch", 8'($urandom));

    // Full 256-byte image: fetch across the wrap point.
    load_image(256, 1, 0);
    check_status("full");
    check_fetch("full_fetch_fe", 8'hFE);
    check_fetch("full_fetch_ff", 8'hFF);
    check_fetch("full_fetch_fd", 8'hFD);
    for (int i = 0; i < 3; i++)
      check_fetch("full_fetch_rnd", 8'($urandom));

    // Known 8-byte program, back to back.
    do_start();
    for (int i = 0; i < 8; i++) send_byte(img[i], i == 7, 0);
    check_status("img");
    fetch_addr = 8'h00;
    #1;
    chk("img_word0", fetch_instr, 32'h00221820);
    fetch_addr = 8'h04;
    #1;
    chk("img_word1", fetch_instr, 32'h04432822);
    @(posedge clk);
    #1;
    check_fetch("img_fetch_8", 8'h08);

    // Same program with 3-cycle valid gaps.
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i], i == 7, 3);
      if (i == 3) chk("gap_count_mid", 32'(byte_count), 32'd4);
    end
    check_status("gap");
    check_fetch("gap_fetch_0", 8'h00);
    check_fetch("gap_fetch_4", 8'h04);
    check_fetch("gap_fetch_8", 8'h08);

    // Six-byte image: misaligned length.
    load_image(6, 1, 1);
    check_status("six");
    check_fetch("six_fetch_4", 8'h04);

    // Start with in_valid in IDLE: only start is taken.
    do_reset();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAB;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    m_load   = 1;
    check_status("startvalid");

    // Start during LOAD is ignored; reset after 5 bytes aborts.
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom), 0, 0);
      if (i == 2) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_status("start_in_load");
        check_fetch("load_fetch_zero", 8'h00);
      end
    end
    do_reset();
    check_status("abort");
    load_image(4, 1, 0);
    check_status("reload");
    check_fetch("reload_fetch_0", 8'h00);
    check_fetch("reload_fetch_4", 8'h04);

    // Random image lengths and gaps.
    for (int k = 0; k < 4; k++) begin
      load_image($urandom_range(20, 1), 1, 2);
      check_status("rnd");
      check_fetch("rnd_fetch", 8'($urandom));
      check_fetch("rnd_fetch_wrap", 8'hFE);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
